// File: rtl/ad_pkt_arbiter.sv
// ad_pkt_arbiter: round-robin packet scheduler sharing one AXI-Stream DMA
// master between CH_NUM packet FIFOs. Whole PKT_WORDS packets are moved
// atomically and each beat carries its channel index on m_axis_tuser.
// Ports: dma_clk/rst1_n (async, active low), enable run control,
//   ch_empty/ch_almost_empty/ch_dout/ch_rd_en to the channel FIFOs
//   (std read, 1-cycle latency), m_axis_* stream master, busy,
//   pkt_count (delivered packets, wraps), pkt_err.
// Optional: define AD_PKT_CHECK_EN to check each packet (XOR of all words
//   must be 0, word PKT_WORDS-3 bits[31:24] must be grant+1); otherwise
//   pkt_err is tied low.
module ad_pkt_arbiter #(
    parameter int CH_NUM    = 4,
    parameter int CH_W      = 2,
    parameter int PKT_WORDS = 1024
) (
    input  logic                  dma_clk,
    input  logic                  rst1_n,
    input  logic                  enable,
    input  logic [CH_NUM-1:0]     ch_empty,
    input  logic [CH_NUM-1:0]     ch_almost_empty,
    input  logic [32*CH_NUM-1:0]  ch_dout,
    output logic [CH_NUM-1:0]     ch_rd_en,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CH_W-1:0]       m_axis_tuser,
    output logic                  busy,
    output logic [31:0]           pkt_count,
    output logic                  pkt_err
);

    localparam int BW = $clog2(PKT_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [BW:0]     issued_q, issued_d;
    logic [BW-1:0]   beat_q;
    logic            pend_q;
    logic [31:0]     mem_q [4];
    logic [1:0]      wr_q, rd_q;
    logic [2:0]      occ_q;
    logic [31:0]     cnt_q;

    logic            rd, hs, last_hs, found;
    logic [CH_W-1:0] win, cand;
    logic [31:0]     rd_word;

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int i = 1; i <= CH_NUM; i++) begin
            cand = CH_W'((int'(ptr_q) + i) % CH_NUM);
            if (!found && !ch_almost_empty[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // A read is allowed only while the words already buffered plus the
    // one in flight leave room for it, so the 4-entry buffer never fills.
    assign rd = (state_q == S_XFER)
              && (issued_q < (BW+1)'(PKT_WORDS))
              && !ch_empty[ptr_q]
              && ((occ_q + {2'b0, pend_q}) <= 3'd2);

    always_comb begin
        ch_rd_en        = '0;
        ch_rd_en[ptr_q] = rd;
    end

    assign rd_word       = ch_dout[32*ptr_q +: 32];
    assign m_axis_tvalid = (occ_q != 3'd0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_q] : 32'd0;
    assign m_axis_tuser  = m_axis_tvalid ? ptr_q : '0;
    assign m_axis_tlast  = m_axis_tvalid
                         && (beat_q == BW'(PKT_WORDS - 1));
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign last_hs       = hs && m_axis_tlast;
    assign busy          = (state_q != S_IDLE);
    assign pkt_count     = cnt_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ARB;
            end
            S_ARB: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    ptr_d    = win;
                    issued_d = '0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                if (rd) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_q == (BW+1)'(PKT_WORDS - 1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_hs) state_d = enable ? S_ARB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dma_clk or negedge rst1_n) begin
        if (!rst1_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= CH_W'(CH_NUM - 1);
            issued_q <= '0;
            beat_q   <= '0;
            pend_q   <= 1'b0;
            wr_q     <= 2'd0;
            rd_q     <= 2'd0;
            occ_q    <= 3'd0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            issued_q <= issued_d;
            pend_q   <= rd;
            occ_q    <= occ_q + {2'b0, pend_q} - {2'b0, hs};
            if (pend_q) wr_q <= wr_q + 2'd1;
            if (hs) begin
                rd_q   <= rd_q + 2'd1;
                beat_q <= m_axis_tlast ? '0 : beat_q + 1'b1;
            end
            if (last_hs) cnt_q <= cnt_q + 32'd1;
        end
    end

    // Buffer storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge dma_clk) begin
        if (pend_q) mem_q[wr_q] <= rd_word;
    end

`ifdef AD_PKT_CHECK_EN
    logic [31:0] xor_q;
    logic        id_bad_q;
    logic        err_q;

    always_ff @(posedge dma_clk or negedge rst1_n) begin
        if (!rst1_n) begin
            xor_q    <= 32'd0;
            id_bad_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (last_hs) begin
                err_q    <= ((xor_q ^ m_axis_tdata) != 32'd0) || id_bad_q;
                xor_q    <= 32'd0;
                id_bad_q <= 1'b0;
            end else if (hs) begin
                xor_q <= xor_q ^ m_axis_tdata;
                if (beat_q == BW'(PKT_WORDS - 3))
                    id_bad_q <= m_axis_tdata[31:24] != (8'(ptr_q) + 8'd1);
            end
        end
    end

    assign pkt_err = err_q;
`else
    assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_ad_pkt_arbiter.sv
// tb_ad_pkt_arbiter: directed bench for ad_pkt_arbiter with bench-side
// channel FIFO models and an in-order expected-beat queue.
module tb_ad_pkt_arbiter;

    localparam int P = 1024;
`ifdef AD_PKT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         dma_clk;
    logic         rst1_n;
    logic         enable;
    logic [3:0]   ch_empty;
    logic [3:0]   ch_almost_empty;
    logic [127:0] ch_dout;
    logic [3:0]   ch_rd_en;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [1:0]   m_axis_tuser;
    logic         busy;
    logic [31:0]  pkt_count;
    logic         pkt_err;

    ad_pkt_arbiter #(.CH_NUM(4), .CH_W(2), .PKT_WORDS(P)) dut (
        .dma_clk         (dma_clk),
        .rst1_n          (rst1_n),
        .enable          (enable),
        .ch_empty        (ch_empty),
        .ch_almost_empty (ch_almost_empty),
        .ch_dout         (ch_dout),
        .ch_rd_en        (ch_rd_en),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .busy            (busy),
        .pkt_count       (pkt_count),
        .pkt_err         (pkt_err)
    );

    initial dma_clk = 1'b0;
    always #5 dma_clk = ~dma_clk;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  u;
        logic        l;
        logic        bad;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] fq[4][$];
    logic [31:0] pk[P];
    logic [31:0] dout[4];
    logic [3:0]  hold, prev_rd;
    bit          rnd_ready;
    logic        rdy_lvl;
    int          total, bad, hs_cnt, err_cnt, ncyc;
    logic        err_exp, hs_now, last_now;
    bit          hold_prev;
    logic [31:0] p_d;
    logic [1:0]  p_u;
    logic        p_l;

    // mode 0 clean, 1 word 17 corrupted after CRC, 2 wrong channel id
    task automatic gen_push(input int c, input int p, input int mode);
        logic [31:0] x;
        beat_t e;
        x = 32'd0;
        for (int i = 0; i < P - 1; i++) begin
            if (i == P - 3)
                pk[i] = {8'(c + 1 + (mode == 2 ? 1 : 0)), 8'(p), 16'hC0DE};
            else
                pk[i] = {4'(c), 4'(p), 24'(i * 7 + 13)};
            x = x ^ pk[i];
        end
        pk[P-1] = x;
        if (mode == 1) pk[17] = pk[17] ^ 32'h0000_0100;
        for (int i = 0; i < P; i++) begin
            fq[c].push_back(pk[i]);
            e.d   = pk[i];
            e.u   = 2'(c);
            e.l   = (i == P - 1);
            e.bad = (mode != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        beat_t e;
        logic  nerr;
        @(posedge dma_clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (prev_rd[c] && fq[c].size() > 0) dout[c] = fq[c].pop_front();
            ch_dout[32*c +: 32] = dout[c];
            ch_empty[c]         = (fq[c].size() == 0) || hold[c];
            ch_almost_empty[c]  = (fq[c].size() < 16);
        end
        m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : rdy_lvl;
        #1;
        ncyc++;
        hs_now   = 1'b0;
        last_now = 1'b0;
        nerr     = 1'b0;
        total++;
        if ($countones(ch_rd_en) > 1) begin
            bad++;
            $display("FAIL rd_onehot: rd_en=%b required <=1 bit", ch_rd_en);
        end
        total++;
        if ((ch_rd_en & ch_empty) != 4'd0) begin
            bad++;
            $display("FAIL rd_empty: rd_en=%b empty=%b", ch_rd_en, ch_empty);
        end
        total++;
        if (pkt_err !== err_exp) begin
            bad++;
            $display("FAIL pkt_err: got %b required %b", pkt_err, err_exp);
        end
        if (pkt_err === 1'b1) err_cnt++;
        if (m_axis_tvalid && ch_rd_en != 4'd0) begin
            total++;
            if (ch_rd_en != (4'b0001 << m_axis_tuser)) begin
                bad++;
                $display("FAIL rd_grant: rd_en=%b tuser=%0d",
                         ch_rd_en, m_axis_tuser);
            end
        end
        if (hold_prev) begin
            total++;
            if (!m_axis_tvalid || m_axis_tdata !== p_d
                || m_axis_tuser !== p_u || m_axis_tlast !== p_l) begin
                bad++;
                $display("FAIL stable: got v=%b d=%h u=%0d l=%b req d=%h u=%0d l=%b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tuser,
                         m_axis_tlast, p_d, p_u, p_l);
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            hs_now   = 1'b1;
            last_now = m_axis_tlast;
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat: d=%h u=%0d", m_axis_tdata, m_axis_tuser);
            end else begin
                e = exp_q.pop_front();
                if ({m_axis_tdata, m_axis_tuser, m_axis_tlast}
                    !== {e.d, e.u, e.l}) begin
                    bad++;
                    $display("FAIL beat %0d: got d=%h u=%0d l=%b req d=%h u=%0d l=%b",
                             hs_cnt, m_axis_tdata, m_axis_tuser, m_axis_tlast,
                             e.d, e.u, e.l);
                end
                nerr = CHK && e.l && e.bad;
            end
        end
        err_exp   = nerr;
        hold_prev = m_axis_tvalid && !m_axis_tready;
        p_d       = m_axis_tdata;
        p_u       = m_axis_tuser;
        p_l       = m_axis_tlast;
        prev_rd   = ch_rd_en;
    endtask

    task automatic clear_model();
        for (int c = 0; c < 4; c++) begin
            fq[c].delete();
            dout[c] = 32'd0;
        end
        exp_q.delete();
        hold      = 4'd0;
        prev_rd   = 4'd0;
        hold_prev = 1'b0;
        err_exp   = 1'b0;
        hs_cnt    = 0;
        err_cnt   = 0;
        rnd_ready = 1'b0;
        rdy_lvl   = 1'b1;
    endtask

    task automatic do_reset();
        rst1_n = 1'b0;
        enable = 1'b0;
        clear_model();
        repeat (3) cyc();
        rst1_n = 1'b1;
        cyc();
    endtask

    task automatic run_pkts(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (pkt_count != 32'(n) && k < budget) begin
            cyc();
            k++;
        end
        ok = (pkt_count == 32'(n));
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        enable = 1'b0;
        clear_model();
        repeat (2) cyc();
        total++;
        if (m_axis_tvalid !== 1'b0) begin
            bad++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid);
        end
        total++;
        if (m_axis_tdata !== 32'd0) begin
            bad++; $display("FAIL rst_tdata: got %h required 0", m_axis_tdata);
        end
        total++;
        if (m_axis_tlast !== 1'b0 || m_axis_tuser !== 2'd0) begin
            bad++; $display("FAIL rst_tlast_tuser: got %b/%0d required 0/0",
                            m_axis_tlast, m_axis_tuser);
        end
        total++;
        if (ch_rd_en !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_rd_busy: got %b/%b required 0/0",
                            ch_rd_en, busy);
        end
        total++;
        if (pkt_count !== 32'd0 || pkt_err !== 1'b0) begin
            bad++; $display("FAIL rst_cnt_err: got %0d/%b required 0/0",
                            pkt_count, pkt_err);
        end
        rst1_n = 1'b1;
        repeat (5) cyc();
        total++;
        if (busy !== 1'b0 || ch_rd_en !== 4'd0) begin
            bad++; $display("FAIL idle_hold: busy=%b rd=%b required 0/0",
                            busy, ch_rd_en);
        end
    endtask

    task automatic test_single();
        int first, lastc, k;
        do_reset();
        gen_push(0, 0, 0);
        enable = 1'b1;
        first  = -1;
        lastc  = -1;
        k      = 0;
        while (pkt_count != 32'd1 && k < 3000) begin
            cyc();
            k++;
            if (hs_now && first < 0) first = ncyc;
            if (hs_now && last_now) lastc = ncyc;
        end
        total++;
        if (pkt_count !== 32'd1) begin
            bad++; $display("FAIL single_count: got %0d required 1", pkt_count);
        end
        total++;
        if (lastc - first != P - 1) begin
            bad++; $display("FAIL single_b2b: span %0d required %0d",
                            lastc - first, P - 1);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL single_left: %0d beats missing required 0",
                            exp_q.size());
        end
        enable = 1'b0;
        repeat (4) cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 4; c++)
                gen_push(c, p, 0);
        enable = 1'b1;
        run_pkts(12, 14000, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rr_count: got %0d required 12", pkt_count);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rr_left: %0d beats missing required 0",
                            exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int k, srd;
        do_reset();
        gen_push(0, 0, 0);
        gen_push(0, 1, 0);
        rnd_ready = 1'b1;
        enable    = 1'b1;
        k         = 0;
        while (fq[0].size() > 2 * P - 300 && k < 2000) begin
            cyc();
            k++;
        end
        total++;
        if (fq[0].size() > 2 * P - 300) begin
            bad++; $display("FAIL stall_start: fifo=%0d required <=%0d",
                            fq[0].size(), 2 * P - 300);
        end
        hold[0] = 1'b1;
        srd     = 0;
        repeat (40) begin
            cyc();
            if (ch_rd_en != 4'd0) srd++;
        end
        total++;
        if (srd != 0) begin
            bad++; $display("FAIL stall_rd: %0d reads required 0", srd);
        end
        total++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL stall_drain: tvalid=%b busy=%b required 0/1",
                            m_axis_tvalid, busy);
        end
        hold[0] = 1'b0;
        run_pkts(2, 9000, ok);
        total++;
        if (!ok || exp_q.size() != 0) begin
            bad++; $display("FAIL stall_done: count=%0d left=%0d required 2/0",
                            pkt_count, exp_q.size());
        end
        rnd_ready = 1'b0;
    endtask

    task automatic test_disable();
        int k, nrd;
        do_reset();
        gen_push(1, 0, 0);
        gen_push(1, 1, 0);
        while (exp_q.size() > P) void'(exp_q.pop_back());
        enable = 1'b1;
        k      = 0;
        while (hs_cnt < 500 && k < 2000) begin
            cyc();
            k++;
        end
        enable = 1'b0;
        k      = 0;
        while (busy && k < 2000) begin
            cyc();
            k++;
        end
        total++;
        if (busy !== 1'b0 || pkt_count !== 32'd1) begin
            bad++; $display("FAIL dis_finish: busy=%b count=%0d required 0/1",
                            busy, pkt_count);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL dis_left: %0d beats missing required 0",
                            exp_q.size());
        end
        nrd = 0;
        repeat (50) begin
            cyc();
            if (ch_rd_en != 4'd0) nrd++;
        end
        total++;
        if (nrd != 0 || fq[1].size() != P) begin
            bad++; $display("FAIL dis_noread: reads=%0d fifo=%0d required 0/%0d",
                            nrd, fq[1].size(), P);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        do_reset();
        gen_push(2, 0, 0);
        gen_push(3, 0, 0);
        enable = 1'b1;
        k      = 0;
        while (hs_cnt < P + 100 && k < 3000) begin
            cyc();
            k++;
        end
        rst1_n = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0
            || m_axis_tlast !== 1'b0 || m_axis_tuser !== 2'd0) begin
            bad++; $display("FAIL mid_stream: v=%b d=%h l=%b u=%0d required 0",
                            m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                            m_axis_tuser);
        end
        total++;
        if (ch_rd_en !== 4'd0 || busy !== 1'b0 || pkt_count !== 32'd0) begin
            bad++; $display("FAIL mid_ctrl: rd=%b busy=%b count=%0d required 0",
                            ch_rd_en, busy, pkt_count);
        end
        enable = 1'b0;
        clear_model();
        repeat (2) cyc();
        rst1_n = 1'b1;
        gen_push(0, 5, 0);
        gen_push(1, 5, 0);
        enable = 1'b1;
        k      = 0;
        cyc();
        while (ch_rd_en == 4'd0 && k < 20) begin
            cyc();
            k++;
        end
        total++;
        if (ch_rd_en !== 4'b0001) begin
            bad++; $display("FAIL mid_first_grant: rd=%b required 0001", ch_rd_en);
        end
        run_pkts(2, 3000, ok);
        total++;
        if (!ok || exp_q.size() != 0) begin
            bad++; $display("FAIL mid_done: count=%0d left=%0d required 2/0",
                            pkt_count, exp_q.size());
        end
    endtask

    task automatic test_check();
        bit ok;
        do_reset();
        gen_push(0, 2, 0);
        gen_push(1, 2, 2);
        gen_push(2, 2, 1);
        gen_push(3, 2, 0);
        enable = 1'b1;
        run_pkts(4, 6000, ok);
        cyc();
        cyc();
        total++;
        if (!ok || exp_q.size() != 0) begin
            bad++; $display("FAIL chk_done: count=%0d left=%0d required 4/0",
                            pkt_count, exp_q.size());
        end
        total++;
        if (err_cnt != (CHK ? 2 : 0)) begin
            bad++; $display("FAIL chk_pulses: got %0d required %0d",
                            err_cnt, CHK ? 2 : 0);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        ncyc          = 0;
        rst1_n        = 1'b0;
        enable        = 1'b0;
        ch_empty      = 4'hF;
        ch_almost_empty = 4'hF;
        ch_dout       = '0;
        m_axis_tready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_disable();
        test_reset_mid();
        test_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
